// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift array,
// emitting one registered window per accepted raster pixel once two rows/cols of history exist.
module conv_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] w4,
    output logic [DATA_W-1:0] w5,
    output logic [DATA_W-1:0] w6,
    output logic [DATA_W-1:0] w7,
    output logic [DATA_W-1:0] w8,
    output logic              win_valid,
    output logic [CNT_W-1:0]  win_row,
    output logic [CNT_W-1:0]  win_col,
    output logic              frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [CNT_W-1:0]  row_reg, col_reg;
    logic [CNT_W-1:0]  row_next, col_next;
    logic [CNT_W-1:0]  cur_row, cur_col;
    logic [AW-1:0]     lb_addr;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic              win_ok;
    logic              last_pix;

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] win_reg [9];
    logic [DATA_W-1:0] col_in  [3];

    logic              win_valid_reg, frame_done_reg;
    logic [CNT_W-1:0]  win_row_reg, win_col_reg;

    // sof forces the accepted pixel to (0,0), abandoning any partial frame
    always_comb begin
        cur_row  = sof ? '0 : row_reg;
        cur_col  = sof ? '0 : col_reg;
        row_next = cur_row;
        col_next = cur_col + 1'b1;
        if (cur_col == LAST_COL) begin
            col_next = '0;
            row_next = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
        end
    end

    assign win_ok   = (cur_row >= TWO) && (cur_col >= TWO);
    assign last_pix = (cur_row == LAST_ROW) && (cur_col == LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (pix_valid) begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    // Line buffers: asynchronous read so the new window column sees pre-write contents
    assign lb_addr = cur_col[AW-1:0];
    assign lb0_rd  = lb0_mem[lb_addr];
    assign lb1_rd  = lb1_mem[lb_addr];

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_mem[lb_addr] <= lb0_rd;
            lb0_mem[lb_addr] <= pix_in;
        end
    end

    assign col_in[0] = lb1_rd;
    assign col_in[1] = lb0_rd;
    assign col_in[2] = pix_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win_reg[i] <= '0;
            end
        end else if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_reg[3*i]     <= win_reg[3*i+1];
                win_reg[3*i + 1] <= win_reg[3*i+2];
                win_reg[3*i + 2] <= col_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
        end else begin
            win_valid_reg  <= pix_valid && win_ok;
            frame_done_reg <= pix_valid && last_pix;
            if (pix_valid && win_ok) begin
                win_row_reg <= cur_row - TWO;
                win_col_reg <= cur_col - TWO;
            end
        end
    end

    assign w0         = win_reg[0];
    assign w1         = win_reg[1];
    assign w2         = win_reg[2];
    assign w3         = win_reg[3];
    assign w4         = win_reg[4];
    assign w5         = win_reg[5];
    assign w6         = win_reg[6];
    assign w7         = win_reg[7];
    assign w8         = win_reg[8];
    assign win_valid  = win_valid_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator for the CNN datapath.
- Accepts one raster-order pixel per cycle and buffers the previous two image rows in internal line buffers.
- For every accepted pixel with at least two rows and two columns of history, presents the nine pixels of the 3x3 neighbourhood as nine registered 16-bit words.
- Sits directly upstream of the per-window multiply / nine-input adder tree stage; its nine outputs map one-to-one onto that stage's nine operands.

Parameters:
- DATA_W, 16, pixel and window word width.
- IMG_W, 28, pixels per image row (>=3).
- IMG_H, 28, rows per image (>=3).
- CNT_W, 8, width of row/column counters and coordinate outputs (must hold IMG_W-1 and IMG_H-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sof  input  1  start of frame; qualifies the pixel on the same cycle as image pixel (0,0).
- pix_in  input  DATA_W  pixel data.
- pix_valid  input  1  pixel accepted on a rising clk when high.
- w0..w8  output  DATA_W each  window words, row-major: w0 = (r-2,c-2), w1 = (r-2,c-1), w2 = (r-2,c), w3 = (r-1,c-2) ... w8 = (r,c) = newest pixel.
- win_valid  output  1  window words valid this cycle.
- win_row  output  CNT_W  top-left row of the window (r-2).
- win_col  output  CNT_W  top-left column of the window (c-2).
- frame_done  output  1  one-cycle pulse with the last window of the frame.

Behaviour:
- Reset (rst_n low, asynchronous): w0..w8, win_valid, win_row, win_col and frame_done all go to 0. Row/column counters and the 3x3 shift registers clear. Line-buffer RAM content is don't-care, because validity is gated by the counters. Reset mid-frame discards the frame; the next accepted pixel is (0,0) whether or not sof is present.
- Counters: col counts 0..IMG_W-1 on each accepted pixel. On wrap, col returns to 0 and row increments. After pixel (IMG_H-1, IMG_W-1), row and col both return to 0.
- sof with pix_valid: that pixel is (0,0) regardless of counter state, which aborts any partial frame. sof without pix_valid is ignored.
- Line buffers: two IMG_W-deep buffers. LB0 holds row r-1 and LB1 holds row r-2, both addressed by col. On accept: LB1[col] <= LB0[col]; LB0[col] <= pix_in.
- Window shift: on accept, each window row shifts left by one column. The new right column is {LB1[col], LB0[col], pix_in} using pre-write values.
- Latency: 1 cycle. The window for pixel (r,c) accepted at edge N is on w0..w8 after edge N, with win_valid high for exactly that cycle.
- win_valid condition: win_valid = 1 iff the pixel accepted at the previous edge had r>=2 and c>=2. This yields (IMG_H-2)*(IMG_W-2) windows per frame. Windows never straddle a row boundary (c<2 suppressed).
- Stall: when pix_valid is low, counters, buffers and window contents hold, and win_valid is 0 the following cycle. w0..w8 retain their last values.
- frame_done: high in the same cycle as the win_valid for pixel (IMG_H-1, IMG_W-1), and never otherwise.
- Back-to-back frames: no bubble is required. Pixel (0,0) of the next frame may follow the last pixel immediately.
- Arithmetic: no arithmetic on pixel data; values pass bit-exact. Counter comparisons are unsigned.

Test Plan:
- Single frame, IMG_W=IMG_H=4, pixels = 4r+c, continuous pix_valid, sof on the first pixel:
  - First win_valid one cycle after pixel 10 is accepted, with w0..w8 = 0,1,2,4,5,6,8,9,10 and win_row=0, win_col=0.
  - Then windows at (0,1), (1,0), (1,1) ending 11,14,15.
  - Exactly 4 win_valid pulses; frame_done coincides with the window whose w8=15.
- Same frame with pix_valid low for 3 cycles after pixel 9 and every other cycle thereafter: identical 4 windows and values; win_valid only follows accepted pixels.
- Reset mid-frame: rst_n low after pixel 7, then restart the frame without sof: outputs 0 during reset, and the windows produced equal the first scenario exactly.
- sof mid-frame: after 6 pixels of frame A, assert sof with a new 4x4 frame B (values 100+4r+c): no window contains frame A data; first window is 100,101,102,104,105,106,108,109,110.
- Back-to-back: two 4x4 frames streamed with no gap: 8 windows total, 2 frame_done pulses, and frame 2's first window contains only frame 2 pixels.
